// File: rtl/iob_sync_asym_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: width arithmetic, default unit counts,
// flag type and reset constants.
package iob_asym_fifo_pkg;

    function automatic int unsigned min_w_f(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned max_w_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned ratio_f(input int unsigned a, input int unsigned b);
        return max_w_f(a, b) / min_w_f(a, b);
    endfunction

    function automatic int unsigned log2_ratio_f(input int unsigned a, input int unsigned b);
        return $clog2(ratio_f(a, b));
    endfunction

    localparam int unsigned DEF_W_DATA_W = 32;
    localparam int unsigned DEF_R_DATA_W = 8;
    localparam int unsigned W_UNITS = DEF_W_DATA_W / min_w_f(DEF_W_DATA_W, DEF_R_DATA_W);
    localparam int unsigned R_UNITS = DEF_R_DATA_W / min_w_f(DEF_W_DATA_W, DEF_R_DATA_W);

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1};
    localparam logic        ERR_RST   = 1'b0;

endpackage

// File: rtl/iob_sync_asym_ram.sv
// Single-clock asymmetric RAM: MAX_W-wide rows, narrow side selects a MIN_W lane.
// Addresses are in each port's own word units; read data is registered with enable.
module iob_sync_asym_ram
    import iob_asym_fifo_pkg::*;
#(
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                                                         clk_i,
    input  logic                                                         rst_ni,
    input  logic                                                         w_en_i,
    input  logic [ADDR_W-$clog2(W_DATA_W/min_w_f(W_DATA_W,R_DATA_W))-1:0] w_addr_i,
    input  logic [W_DATA_W-1:0]                                          w_data_i,
    input  logic                                                         r_en_i,
    input  logic [ADDR_W-$clog2(R_DATA_W/min_w_f(W_DATA_W,R_DATA_W))-1:0] r_addr_i,
    output logic [R_DATA_W-1:0]                                          r_data_o
);

    localparam int unsigned MIN_W = min_w_f(W_DATA_W, R_DATA_W);
    localparam int unsigned MAX_W = max_w_f(W_DATA_W, R_DATA_W);
    localparam int unsigned RATIO = ratio_f(W_DATA_W, R_DATA_W);
    localparam int unsigned LOG2R = log2_ratio_f(W_DATA_W, R_DATA_W);
    localparam int unsigned ROW_W = ADDR_W - LOG2R;
    localparam int unsigned ROWS  = 2 ** ROW_W;

    logic [MAX_W-1:0]    mem [ROWS];
    logic [R_DATA_W-1:0] rd_word;
    logic [R_DATA_W-1:0] r_data_q;

    generate
        if (W_DATA_W == MAX_W) begin : g_wr_wide
            always_ff @(posedge clk_i) begin
                if (w_en_i) mem[w_addr_i] <= w_data_i;
            end
        end else begin : g_wr_lane
            logic [ROW_W-1:0] w_row;
            logic [LOG2R-1:0] w_lane;
            assign w_row  = w_addr_i[ADDR_W-1:LOG2R];
            assign w_lane = w_addr_i[LOG2R-1:0];
            always_ff @(posedge clk_i) begin
                if (w_en_i) begin
                    for (int unsigned i = 0; i < RATIO; i++) begin
                        if (w_lane == LOG2R'(i)) mem[w_row][i*MIN_W +: MIN_W] <= w_data_i;
                    end
                end
            end
        end

        if (R_DATA_W == MAX_W) begin : g_rd_wide
            always_comb rd_word = mem[r_addr_i];
        end else begin : g_rd_lane
            logic [ROW_W-1:0] r_row;
            logic [LOG2R-1:0] r_lane;
            logic [MAX_W-1:0] r_row_word;
            assign r_row      = r_addr_i[ADDR_W-1:LOG2R];
            assign r_lane     = r_addr_i[LOG2R-1:0];
            assign r_row_word = mem[r_row];
            always_comb begin
                rd_word = '0;
                for (int unsigned i = 0; i < RATIO; i++) begin
                    if (r_lane == LOG2R'(i)) rd_word = r_row_word[i*MIN_W +: MIN_W];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni)     r_data_q <= '0;
        else if (r_en_i) r_data_q <= rd_word;
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/iob_sync_asym_fifo.sv
// Single-clock FIFO with independent write/read widths over an asymmetric RAM.
// Sticky w_err/r_err flags are built only when IOB_ASYM_FIFO_ERR_EN is defined.
module iob_sync_asym_fifo
    import iob_asym_fifo_pkg::*;
#(
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                w_err,
    output logic                r_err
);

    localparam int unsigned MIN_W     = min_w_f(W_DATA_W, R_DATA_W);
    localparam int unsigned N_W_UNITS = W_DATA_W / MIN_W;
    localparam int unsigned N_R_UNITS = R_DATA_W / MIN_W;
    localparam int unsigned CAP       = 2 ** ADDR_W;
    localparam int unsigned WA_W      = ADDR_W - $clog2(N_W_UNITS);
    localparam int unsigned RA_W      = ADDR_W - $clog2(N_R_UNITS);

    localparam logic [ADDR_W:0] LVL_W_INC = (ADDR_W+1)'(N_W_UNITS);
    localparam logic [ADDR_W:0] LVL_R_DEC = (ADDR_W+1)'(N_R_UNITS);
    localparam logic [ADDR_W:0] FULL_THR  = (ADDR_W+1)'(CAP - N_W_UNITS);
    localparam logic [ADDR_W:0] EMPTY_THR = (ADDR_W+1)'(N_R_UNITS);

    // Pointers hold only the bits above the always-zero alignment bits, so each
    // advances by one of its own words, i.e. by W_UNITS/R_UNITS min-words.
    logic [WA_W-1:0]   wptr_q, wptr_d;
    logic [RA_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    fifo_flags_t       flags_q, flags_d;
    logic              w_acc, r_acc;

    always_comb begin
        w_acc   = w_en && !flags_q.full;
        r_acc   = r_en && !flags_q.empty;
        wptr_d  = w_acc ? wptr_q + WA_W'(1) : wptr_q;
        rptr_d  = r_acc ? rptr_q + RA_W'(1) : rptr_q;
        level_d = level_q;
        if (w_acc) level_d = level_d + LVL_W_INC;
        if (r_acc) level_d = level_d - LVL_R_DEC;
        flags_d       = flags_q;
        flags_d.full  = level_d > FULL_THR;
        flags_d.empty = level_d < EMPTY_THR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            flags_q <= flags_d;
        end
    end

`ifdef IOB_ASYM_FIFO_ERR_EN
    logic w_err_q, w_err_d;
    logic r_err_q, r_err_d;

    always_comb begin
        w_err_d = w_err_q | (w_en & flags_q.full);
        r_err_d = r_err_q | (r_en & flags_q.empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_err_q <= ERR_RST;
            r_err_q <= ERR_RST;
        end else begin
            w_err_q <= w_err_d;
            r_err_q <= r_err_d;
        end
    end

    assign w_err = w_err_q;
    assign r_err = r_err_q;
`else
    assign w_err = 1'b0;
    assign r_err = 1'b0;
`endif

    iob_sync_asym_ram #(
        .W_DATA_W (W_DATA_W),
        .R_DATA_W (R_DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .w_en_i   (w_acc),
        .w_addr_i (wptr_q),
        .w_data_i (w_data),
        .r_en_i   (r_acc),
        .r_addr_i (rptr_q),
        .r_data_o (r_data)
    );

    assign w_full  = flags_q.full;
    assign r_empty = flags_q.empty;
    assign level   = level_q;

endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// Directed bench for iob_sync_asym_fifo: a 32->8 instance (A) and an 8->32 instance (B).
module tb_iob_sync_asym_fifo;

`ifdef IOB_ASYM_FIFO_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;

    logic        a_w_en, a_r_en, a_w_full, a_r_empty, a_w_err, a_r_err;
    logic [31:0] a_w_data;
    logic [7:0]  a_r_data;
    logic [4:0]  a_level;

    logic        b_w_en, b_r_en, b_w_full, b_r_empty, b_w_err, b_r_err;
    logic [7:0]  b_w_data;
    logic [31:0] b_r_data;
    logic [4:0]  b_level;

    always #5 clk = ~clk;

    iob_sync_asym_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
        .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty), .level(a_level),
        .w_err(a_w_err), .r_err(a_r_err)
    );

    iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
        .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty), .level(b_level),
        .w_err(b_w_err), .r_err(b_r_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_w_en = 1'b1; a_r_en = 1'b1; a_w_data = 32'hFFFF_FFFF;
        b_w_en = 1'b1; b_r_en = 1'b1; b_w_data = 8'hFF;
        repeat (3) step();
        checks++; if (a_level !== 5'd0) begin failures++; $display("FAIL rst_a_level got=%0d exp=0", a_level); end
        checks++; if (a_r_empty !== 1'b1) begin failures++; $display("FAIL rst_a_empty got=%b exp=1", a_r_empty); end
        checks++; if (a_w_full !== 1'b0) begin failures++; $display("FAIL rst_a_full got=%b exp=0", a_w_full); end
        checks++; if (a_r_data !== 8'h00) begin failures++; $display("FAIL rst_a_rdata got=%h exp=00", a_r_data); end
        checks++; if ({a_w_err, a_r_err} !== 2'b00) begin failures++; $display("FAIL rst_a_errs got=%b exp=00", {a_w_err, a_r_err}); end
        checks++; if (b_level !== 5'd0 || b_r_empty !== 1'b1 || b_w_full !== 1'b0) begin
            failures++; $display("FAIL rst_b_status got=%0d/%b/%b exp=0/1/0", b_level, b_r_empty, b_w_full); end
        checks++; if (b_r_data !== 32'h0) begin failures++; $display("FAIL rst_b_rdata got=%h exp=00000000", b_r_data); end
        checks++; if ({b_w_err, b_r_err} !== 2'b00) begin failures++; $display("FAIL rst_b_errs got=%b exp=00", {b_w_err, b_r_err}); end
        rst_n = 1'b1;
        a_w_en = 1'b0; a_r_en = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0;
        step();
    endtask

    task automatic test_wide_write();
        for (int k = 0; k < 4; k++) begin
            a_w_en = 1'b1;
            a_w_data = 32'h2322_2120 + 32'(k) * 32'h0404_0404;
            step();
            checks++; if (a_level !== 5'(4 * (k + 1))) begin failures++; $display("FAIL ww_level got=%0d exp=%0d", a_level, 4 * (k + 1)); end
            checks++; if (a_w_full !== (k == 3)) begin failures++; $display("FAIL ww_full k=%0d got=%b exp=%b", k, a_w_full, k == 3); end
        end
        a_w_en = 1'b0;
        a_r_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (a_r_data !== 8'(8'h20 + i)) begin failures++; $display("FAIL ww_rdata i=%0d got=%h exp=%h", i, a_r_data, 8'(8'h20 + i)); end
        end
        a_r_en = 1'b0;
        checks++; if (a_r_empty !== 1'b1 || a_level !== 5'd0) begin
            failures++; $display("FAIL ww_drained got=%b/%0d exp=1/0", a_r_empty, a_level); end
    endtask

    task automatic test_narrow_write();
        b_w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_w_data = 8'(8'h20 + i);
            step();
            checks++; if (b_r_empty !== (i < 3)) begin failures++; $display("FAIL nw_empty i=%0d got=%b exp=%b", i, b_r_empty, i < 3); end
        end
        b_w_en = 1'b0;
        checks++; if (b_level !== 5'd16 || b_w_full !== 1'b1) begin
            failures++; $display("FAIL nw_full got=%0d/%b exp=16/1", b_level, b_w_full); end
        b_r_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (b_r_data !== 32'h2322_2120 + 32'(k) * 32'h0404_0404) begin
                failures++; $display("FAIL nw_rdata k=%0d got=%h exp=%h", k, b_r_data, 32'h2322_2120 + 32'(k) * 32'h0404_0404); end
        end
        b_r_en = 1'b0;
        checks++; if (b_r_empty !== 1'b1) begin failures++; $display("FAIL nw_drained got=%b exp=1", b_r_empty); end
    endtask

    task automatic test_wrap_simul();
        int lvl = 0, prev, wl = 12, rl = 48, wn = 0, rn = 0, cyc = 0;
        logic wacc, racc;
        logic [7:0] b;
        while ((wl > 0 || rl > 0) && cyc < 200) begin
            b = 8'(32'h40 + 4 * wn);
            a_w_en = (wl > 0);
            a_r_en = (rl > 0);
            a_w_data = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            wacc = a_w_en && !(lvl > 12);
            racc = a_r_en && !(lvl < 1);
            prev = lvl;
            lvl = lvl + (wacc ? 4 : 0) - (racc ? 1 : 0);
            step();
            if (wacc) begin wn++; wl--; end
            checks++; if (a_level !== 5'(lvl) || a_level > 5'd16) begin
                failures++; $display("FAIL wrap_level cyc=%0d got=%0d exp=%0d", cyc, a_level, lvl); end
            if (wacc && racc) begin
                checks++; if (a_level !== 5'(prev + 3)) begin
                    failures++; $display("FAIL wrap_delta cyc=%0d got=%0d exp=%0d", cyc, a_level, prev + 3); end
            end
            if (racc) begin
                checks++; if (a_r_data !== 8'(8'h40 + rn)) begin
                    failures++; $display("FAIL wrap_rdata n=%0d got=%h exp=%h", rn, a_r_data, 8'(8'h40 + rn)); end
                rn++; rl--;
            end
            cyc++;
        end
        a_w_en = 1'b0; a_r_en = 1'b0;
        checks++; if (wl != 0 || rl != 0) begin
            failures++; $display("FAIL wrap_timeout got=%0d/%0d left exp=0/0", wl, rl); end
    endtask

    task automatic test_over_under();
        a_r_en = 1'b1;
        step();
        a_r_en = 1'b0;
        checks++; if (a_level !== 5'd0 || a_r_empty !== 1'b1) begin
            failures++; $display("FAIL uf_state got=%0d/%b exp=0/1", a_level, a_r_empty); end
        checks++; if (a_r_data !== 8'h6F) begin failures++; $display("FAIL uf_rdata_held got=%h exp=6f", a_r_data); end
        checks++; if (a_r_err !== ERR_EXP) begin failures++; $display("FAIL uf_r_err got=%b exp=%b", a_r_err, ERR_EXP); end
        a_w_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_w_data = 32'h1312_1110 + 32'(k) * 32'h0404_0404;
            step();
        end
        a_w_data = 32'hEEEE_EEEE;
        step();
        a_w_en = 1'b0;
        checks++; if (a_level !== 5'd16 || a_w_full !== 1'b1) begin
            failures++; $display("FAIL of_state got=%0d/%b exp=16/1", a_level, a_w_full); end
        checks++; if (a_w_err !== ERR_EXP) begin failures++; $display("FAIL of_w_err got=%b exp=%b", a_w_err, ERR_EXP); end
        checks++; if (a_r_data !== 8'h6F) begin failures++; $display("FAIL of_rdata_held got=%h exp=6f", a_r_data); end
        repeat (3) step();
        a_r_en = 1'b1;
        step();
        a_r_en = 1'b0;
        checks++; if (a_r_data !== 8'h10) begin failures++; $display("FAIL of_storage got=%h exp=10", a_r_data); end
        checks++; if ({a_w_err, a_r_err} !== {ERR_EXP, ERR_EXP}) begin
            failures++; $display("FAIL err_sticky got=%b exp=%b", {a_w_err, a_r_err}, {ERR_EXP, ERR_EXP}); end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if ({a_w_err, a_r_err} !== 2'b00) begin failures++; $display("FAIL err_clear got=%b exp=00", {a_w_err, a_r_err}); end
        a_w_en = 1'b1;
        a_w_data = 32'h0302_0100; step();
        a_w_data = 32'h0706_0504; step();
        a_w_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (a_level !== 5'd0 || a_r_empty !== 1'b1) begin
            failures++; $display("FAIL mid_rst got=%0d/%b exp=0/1", a_level, a_r_empty); end
        a_w_en = 1'b1;
        a_w_data = 32'hDDCC_BBAA;
        step();
        a_w_en = 1'b0;
        a_r_en = 1'b1;
        step();
        a_r_en = 1'b0;
        checks++; if (a_r_data !== 8'hAA) begin failures++; $display("FAIL mid_rst_data got=%h exp=aa", a_r_data); end
        checks++; if (a_level !== 5'd3) begin failures++; $display("FAIL mid_rst_level got=%0d exp=3", a_level); end
    endtask

    initial begin
        test_reset();
        test_wide_write();
        test_narrow_write();
        test_wrap_simul();
        test_over_under();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_sync_asym_fifo.md
# iob_sync_asym_fifo

Single-clock FIFO with independent write and read widths (either side may be the wider one) built on an internal asymmetric RAM. It sits between a producer and consumer of different word sizes in the same clock domain, such as 32-bit bus writes drained as bytes, or bytes packed into 32-bit reads. It generalises the two-port asymmetric RAM into a flow-controlled queue with level tracking and full/empty handshakes.

## Interface
- W_DATA_W, 32, write word width; power of two, ≥ 8
- R_DATA_W, 8, read word width; power of two, ≥ 8
- ADDR_W, 4, log2 of capacity counted in min-words (MIN_W = min(W_DATA_W, R_DATA_W)); capacity 2^ADDR_W min-words; require 2^ADDR_W ≥ 2·RATIO
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- w_en  in  1  write request
- w_data  in  W_DATA_W  write word
- w_full  out  1  write refused this cycle
- r_en  in  1  read request
- r_data  out  R_DATA_W  registered read word
- r_empty  out  1  read refused this cycle
- level  out  ADDR_W+1  occupancy in min-words
- w_err  out  1  sticky overflow flag (see Configuration)
- r_err  out  1  sticky underflow flag (see Configuration)

## Operation
- RATIO = max(W,R)/MIN_W; W_UNITS = W_DATA_W/MIN_W; R_UNITS = R_DATA_W/MIN_W.
- Packing is little-endian. The oldest min-word maps to bits [MIN_W-1:0] of a wide read, and bits [MIN_W-1:0] of a wide write are read first.
- w_full = level > 2^ADDR_W − W_UNITS; r_empty = level < R_UNITS.
- Write is accepted iff w_en && !w_full. The write pointer (min-word units, ADDR_W bits) advances by W_UNITS and wraps modulo 2^ADDR_W.
- Read is accepted iff r_en && !r_empty. The read pointer advances by R_UNITS and wraps the same way.
- Pointers stay aligned to their own unit size, so a wide access never straddles the wrap point.
- Refused requests have no effect on pointers, level or storage.
- Simultaneous accepted read and write: level_next = level + W_UNITS − R_UNITS. No bypass is needed, because read gating uses the level before the edge.
- Reset drives pointers = 0, level = 0, r_data = 0, w_err = 0, r_err = 0. Flags become w_full = 0, r_empty = 1.
- Reset mid-operation discards all contents. RAM contents are not cleared but become unreachable.

## Timing
- All state updates on the rising clk edge.
- Accepted write at edge N: level and flags reflect it after N, so the data is readable by a request at edge N+1.
- Accepted read at edge N: r_data is valid from just after N until the next accepted read. r_data holds its value on idle or refused cycles.
- w_full, r_empty and level are registered functions of level, with no combinational path from w_en or r_en.
- Full to not-full and empty to not-empty each take exactly one cycle after the enabling read or write.

## Configuration
- IOB_ASYM_FIFO_ERR_EN defined:
  - w_err is set on the first cycle with w_en && w_full.
  - r_err is set on the first cycle with r_en && r_empty.
  - Both flags are sticky until rst_n = 0.
- IOB_ASYM_FIFO_ERR_EN undefined: w_err and r_err are tied to 0 and no flag logic is synthesised. Ports are present in both builds.

## Structure
- Package iob_asym_fifo_pkg holds:
  - functions for MIN_W, MAX_W, RATIO and log2(RATIO)
  - localparams W_UNITS and R_UNITS
  - the reset constants.
- Sub-module iob_sync_asym_ram: single-clock asymmetric RAM (write port W_DATA_W, read port R_DATA_W, registered read with enable), organised as MAX_W rows with lane select.
- The top holds pointers, level counter, flags and error logic.

## Test plan
- Reset: hold rst_n = 0 three cycles with w_en = r_en = 1 → level = 0, r_empty = 1, w_full = 0, r_data = 0, w_err = r_err = 0.
- W=32, R=8, ADDR_W=4, wide write then narrow reads:
  - Write 0x23222120, 0x27262524, 0x2B2A2928, 0x2F2E2D2C → w_full = 1 and level = 16 after the 4th write.
  - Then read 16 times → r_data = 0x20…0x2F in order, and r_empty = 1 after the last read.
- W=8, R=32, ADDR_W=4, narrow writes then wide reads: write bytes 0x20…0x2F → reads return 0x23222120, 0x27262524, 0x2B2A2928, 0x2F2E2D2C. r_empty stays 1 until the 4th byte is written.
- Wrap plus simultaneous access (W=32, R=8):
  - Stream 12 writes and 48 reads interleaved, with w_en and r_en both high on the same edges.
  - Required: data in order across pointer wrap, and level never exceeds 16.
  - On every edge where both are accepted, level changes by +3.
- Overflow/underflow:
  - r_en on empty, then w_en on full → no state change and r_data held.
  - With IOB_ASYM_FIFO_ERR_EN, r_err = 1 and then w_err = 1, both staying high until reset. Without the macro, both stay 0.
- Mid-operation reset: after 2 writes, pulse rst_n = 0 for one cycle → level = 0, r_empty = 1. The next write/read pair returns the new data, not the stale data.
